ifu_pc: RTL
===========

// Module: ifu_pc
// PURPOSE
//   Fetch-stage program counter: holds PC, computes next PC (seq/branch/jump/jr),
//   drives the word address into instruction memory. Sits directly upstream of
//   the instruction memory; the controller and compare unit supply select and
//   branch inputs. Also counts fetched instructions and, optionally, halts on an
//   illegal fetch address.
// PARAMETERS
//   PC_BASE   32'h0000_3000  reset PC; first word of instruction memory
//   IM_DEPTH  4096           instruction memory depth in 32-bit words
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   reset        in   1   synchronous, active-high reset
//   en           in   1   1: PC advances this cycle; 0: PC, counter hold (stall)
//   npc_sel      in   2   00 PC+4, 01 branch, 10 j/jal, 11 jr
//   br_taken     in   1   branch condition result; used only when npc_sel=01
//   imm16        in   16  branch offset (words, signed)
//   instr_index  in   26  jump target field
//   rs_val       in   32  jr target register value
//   pc           out  32  current PC, to instruction memory address
//   pc4          out  32  pc+4, combinational (link value for jal)
//   retired      out  32  instructions fetched since reset
//   fault        out  1   sticky illegal-fetch flag (ADDR_CHECK_EN only)
//   halted       out  1   fetch frozen (ADDR_CHECK_EN only)
// BEHAVIOUR
//   - Reset (sync, priority over everything incl. HALT): pc=PC_BASE, retired=0,
//     fault=0, halted=0, state=RUN.
//   - pc4 = pc + 32'd4, mod 2^32, no overflow detection.
//   - next PC, combinational:
//       00: pc4
//       01: br_taken ? pc4 + {{14{imm16[15]}}, imm16, 2'b00} : pc4
//       10: {pc4[31:28], instr_index, 2'b00}
//       11: rs_val (unmodified, low bits not masked)
//   - Posedge, state RUN, en=1: pc<=next PC, retired<=retired+1 (wraps
//     32'hFFFF_FFFF -> 0). en=0: all registers hold; npc_sel ignored.
//   - Latency: selected target visible on pc exactly one cycle after the edge.
//   - FSM (ADDR_CHECK_EN): RUN -> HALT when en=1 and next PC illegal; HALT
//     absorbing until reset. Legal = next[1:0]==0 and
//     PC_BASE <= next <= PC_BASE + 4*IM_DEPTH - 4 (default 0x3000..0x6FFC).
//     On the faulting edge: pc NOT updated, retired NOT incremented, fault<=1,
//     halted<=1. In HALT: en and all select inputs ignored.
//   - Range compare in 33-bit arithmetic so PC_BASE+4*IM_DEPTH cannot wrap.
//   - en=0 with an illegal next PC: no fault (check only on advancing edges).
// CONFIGURATION
//   ADDR_CHECK_EN defined: legality check, RUN/HALT FSM, fault/halted live.
//   ADDR_CHECK_EN undefined: no FSM, always RUN; any next PC loaded as is;
//     fault and halted tied to 0; ports still present.
// TESTING
//   1 reset 2 cycles, release, en=1, npc_sel=00 x3 -> pc 3000,3004,3008,300C; retired=3
//   2 pc=3008, sel=01, br_taken=1, imm16=FFFE -> pc=3004; same with br_taken=0 -> 300C
//   3 pc=3000, sel=10, instr_index=26'h0000C03 -> pc=0000300C; pc4=3004 before edge
//   4 sel=11, rs_val=00003010 -> pc=3010; then en=0 two cycles -> pc 3010, retired held
//   5 (ADDR_CHECK_EN) pc=3000, sel=11, rs_val=00003002 -> pc stays 3000, fault=1,
//     halted=1; en=1 sel=00 next 3 cycles -> no change; reset -> pc=3000, fault=0
//   6 (ADDR_CHECK_EN) rs_val=00007000 -> fault; rs_val=00006FFC from reset -> legal, pc=6FFC

Source files
------------

// File: rtl/ifu_pc_if.sv
// rtl/ifu_pc_if.sv - fetch PC control/status bundle between controller and ifu_pc
//
// Purpose: groups the fetch-stage handshake so the controller side (master)
// and the PC block (slave) share one typed connection.
// Signals:
//   en          stall control, 1 = advance this cycle
//   npc_sel     next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr
//   br_taken    branch condition from the compare unit
//   imm16       signed branch offset in words
//   instr_index 26-bit jump target field
//   rs_val      jr target register value
//   pc          current PC (instruction memory address)
//   pc4         pc + 4 (jal link value)
//   retired     instructions fetched since reset
//   fault       sticky illegal-fetch flag
//   halted      fetch frozen
interface ifu_pc_if;
  logic        en;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] retired;
  logic        fault;
  logic        halted;

  modport master (
    output en, npc_sel, br_taken, imm16, instr_index, rs_val,
    input  pc, pc4, retired, fault, halted
  );

  modport slave (
    input  en, npc_sel, br_taken, imm16, instr_index, rs_val,
    output pc, pc4, retired, fault, halted
  );
endinterface

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - fetch-stage program counter with next-PC select and fetch counter
//
// Purpose: holds the PC, selects the next PC (sequential, branch, jump, jr),
// counts fetched instructions. With ADDR_CHECK_EN defined, an advance to an
// illegal address (misaligned or outside instruction memory) is refused and
// the block freezes in HALT until reset.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    ifu_pc_if.slave (see ifu_pc_if.sv for the signal list)
// Optional feature macro: ADDR_CHECK_EN
module ifu_pc #(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic     clk,
  input  logic     reset,
  ifu_pc_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] retired_q;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        advance;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    npc    = pc4;
    case (bus.npc_sel)
      2'b00: npc = pc4;
      2'b01: npc = bus.br_taken ? (pc4 + br_off) : pc4;
      2'b10: npc = {pc4[31:28], bus.instr_index, 2'b00};
      2'b11: npc = bus.rs_val;
      default: npc = pc4;
    endcase
  end

`ifdef ADDR_CHECK_EN
  // Bounds held in 33 bits so PC_BASE + 4*IM_DEPTH cannot wrap to a small value.
  localparam logic [32:0] PC_FIRST = {1'b0, PC_BASE};
  localparam logic [32:0] PC_LAST  = {1'b0, PC_BASE} + (33'(IM_DEPTH) << 2) - 33'd4;

  typedef enum logic {RUN, HALT} state_t;

  state_t state_q;
  state_t state_d;
  logic   legal;

  assign legal = (npc[1:0] == 2'b00) &&
                 ({1'b0, npc} >= PC_FIRST) &&
                 ({1'b0, npc} <= PC_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Legality is only judged on advancing edges; a stalled illegal target is harmless.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.en) begin
          if (legal) advance = 1'b1;
          else       state_d = HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // HALT is only ever entered from a fault, so the sticky flag is the state itself.
  assign bus.fault  = (state_q == HALT);
  assign bus.halted = (state_q == HALT);
`else
  assign advance    = bus.en;
  assign bus.fault  = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_BASE;
      retired_q <= 32'd0;
    end else if (advance) begin
      pc_q      <= npc;
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc4     = pc4;
  assign bus.retired = retired_q;

endmodule
